// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined ripple adder: slice sizing and mode encodings.
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int slice_w(input int size, input int stages);
    return size / stages;
  endfunction

endpackage

// File: rtl/fa.sv
// One-bit full adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_slice.sv
// Combinational W-bit ripple slice; c_msb is the carry into the top bit, used for overflow.
module rca_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    fa u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
  end

  assign cout  = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/pipe_rip_add.sv
// Pipelined ripple-carry add/sub: STAGES registered slices of SIZE/STAGES bits each,
// valid/ready stream with a global stall when the output register is full and blocked.
module pipe_rip_add
  import adder_pkg::*;
#(
  parameter int SIZE   = 16,
  parameter int STAGES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] sum,
  output logic            cout,
  output logic            ovf
);

  localparam int W = slice_w(SIZE, STAGES);

  typedef struct packed {
    logic            valid;
    logic [SIZE-1:0] psum;
    logic            carry;
    logic [SIZE-1:0] a_rem;
    logic [SIZE-1:0] b_rem;
  } stage_t;

  logic stall, adv, ovf_q;

  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    stage_t         src, nxt, q;
    logic [W-1:0]   s;
    logic           co, cm;

    if (k == 0) begin : g_in
      // b is pre-inverted here so every later slice is a plain adder
      always_comb begin
        src       = '0;
        src.valid = in_valid;
        src.carry = (sub == MODE_SUB) ? 1'b1 : cin;
        src.a_rem = a;
        src.b_rem = (sub == MODE_SUB) ? ~b : b;
      end
    end else begin : g_mid
      assign src = g_stg[k-1].q;
    end

    rca_slice #(.W(W)) u_slc (
      .a     (src.a_rem[W-1:0]),
      .b     (src.b_rem[W-1:0]),
      .cin   (src.carry),
      .sum   (s),
      .cout  (co),
      .c_msb (cm)
    );

    always_comb begin
      nxt                  = src;
      nxt.psum[k*W +: W]   = s;
      nxt.carry            = co;
      nxt.a_rem            = src.a_rem >> W;
      nxt.b_rem            = src.b_rem >> W;
    end

    // data only moves with a valid beat so the output holds while it is empty
    always_ff @(posedge clk) begin
      if (!rst_n)         q <= '0;
      else if (adv) begin
        if (src.valid)    q <= nxt;
        else              q.valid <= 1'b0;
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic unused_rem;
      assign unused_rem = ^{q.a_rem, q.b_rem};

      always_ff @(posedge clk) begin
        if (!rst_n)                 ovf_q <= 1'b0;
        else if (adv && src.valid)  ovf_q <= cm ^ co;
      end
    end else begin : g_body
      logic unused_cm;
      assign unused_cm = cm;
    end
  end

  assign out_valid = g_stg[STAGES-1].q.valid;
  assign sum       = g_stg[STAGES-1].q.psum;
  assign cout      = g_stg[STAGES-1].q.carry;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_rip_add.sv
// Scoreboard bench: driver pushes model results on accept, negedge monitors pop and compare.
module tb_pipe_rip_add;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;
  logic        in_valid1, in_ready1, cin1, sub1, out_valid1, cout1, ovf1;
  logic [7:0]  a1, b1, sum1;

  int   total = 0;
  int   bad   = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  bit   rnd_run = 1'b0;

  always #5 clk = ~clk;

  pipe_rip_add #(.SIZE(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipe_rip_add #(.SIZE(8), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(out_valid1),
    .out_ready(1'b1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  // Reference: plain integer arithmetic; overflow as signed result out of range
  function automatic exp_t model(input int n, input longint ua, input longint ub,
                                 input bit ci, input bit sb);
    longint m, half, u, sa, sbv, r;
    exp_t   e;
    m    = (longint'(1) << n) - 1;
    half = longint'(1) << (n - 1);
    if (sb) u = ua + ((~ub) & m) + 1;
    else    u = ua + ub + longint'(ci);
    e.s  = 16'(u & m);
    e.c  = ((u >> n) & 1) != 0;
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sbv  = (ub >= half) ? ub - 2 * half : ub;
    r    = sb ? sa - sbv : sa + sbv + longint'(ci);
    e.o  = (r > half - 1) || (r < -half);
    return e;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (out_valid) begin
        if (q0.size() == 0) chk("spurious0", 1, 0);
        else begin
          e0 = q0[0];
          chk("sum0", sum, e0.s);
          chk("cout0", cout, e0.c);
          chk("ovf0", ovf, e0.o);
          if (out_ready) void'(q0.pop_front());
        end
      end
      if (in_valid && in_ready) q0.push_back(model(16, a, b, cin, sub));
      if (out_valid1) begin
        if (q1.size() == 0) chk("spurious1", 1, 0);
        else begin
          e1 = q1.pop_front();
          chk("sum1", sum1, e1.s);
          chk("cout1", cout1, e1.c);
          chk("ovf1", ovf1, e1.o);
        end
      end
      if (in_valid1 && in_ready1) q1.push_back(model(8, a1, b1, cin1, sub1));
    end
  end

  // randomized backpressure during the random phase
  always @(posedge clk) begin
    if (rnd_run) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send0(input logic [15:0] va, input logic [15:0] vb,
                       input logic vc, input logic vs);
    bit ok;
    int n = 0;
    in_valid = 1'b1; a = va; b = vb; cin = vc; sub = vs;
    do begin
      @(negedge clk);
      ok = in_ready && rst_n;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("send0_timeout", 0, 1);
  endtask

  task automatic idle0();
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic drain0();
    int n = 0;
    while (q0.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain0", q0.size(), 0);
  endtask

  task automatic latency0(input int exp_n);
    int n = 0;
    forever begin
      @(negedge clk);
      if (out_valid || n > 20) break;
      @(posedge clk); #1;
      n++;
    end
    chk("latency0", n, exp_n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    idle0();
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_out_valid1", out_valid1, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);

    // plain add, carry across all slices, signed overflow
    @(posedge clk); #1;
    send0(16'h1234, 16'h0001, 1'b0, 1'b0); idle0();
    latency0(3);
    drain0();
    send0(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send0(16'h7FFF, 16'h0001, 1'b0, 1'b0); idle0();
    drain0();
    // subtract with cin asserted (must be ignored)
    send0(16'h0005, 16'h0007, 1'b1, 1'b1);
    send0(16'h8000, 16'h0001, 1'b1, 1'b1); idle0();
    drain0();

    // back-to-back with a 3-cycle stall on the first result
    fork
      begin
        for (int i = 1; i <= 8; i++) send0(16'(i), 16'(i), 1'b0, 1'b0);
        idle0();
      end
      begin
        int n = 0;
        do begin
          @(posedge clk); #1;
          n++;
        end while (!out_valid && n < 50);
        chk("stall_seen_valid", out_valid, 1);
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain0();

    // reset flush with beats in flight
    send0(16'h1111, 16'h2222, 1'b0, 1'b0);
    send0(16'h3333, 16'h4444, 1'b0, 1'b0);
    send0(16'h5555, 16'h6666, 1'b1, 1'b0); idle0();
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    repeat (10) @(posedge clk);
    #1;

    // random traffic under random backpressure
    rnd_run = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send0(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        idle0();
        @(posedge clk); #1;
      end
    end
    idle0();
    rnd_run = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    drain0();

    // single-stage instance: result one cycle after acceptance
    in_valid1 = 1'b1; a1 = 8'hF0; b1 = 8'h10; cin1 = 1'b0; sub1 = 1'b0;
    @(negedge clk);
    chk("in_ready1", in_ready1, 1);
    @(posedge clk); #1 in_valid1 = 1'b0;
    @(negedge clk);
    chk("latency1_valid", out_valid1, 1);
    chk("s1_sum_f0_10", sum1, 8'h00);
    chk("s1_cout_f0_10", cout1, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      in_valid1 = 1'b1;
      a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom); sub1 = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("drain1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
